// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc: pipeline hazard unit with cache-miss FSM, multi-cycle op scoreboard, forwarding and stall counter
// Ports:
//   CPU_CLK / CPU_RSTN          clock, synchronous active-low reset
//   ICacheMiss / DCacheMiss     cache misses, held until refill completes
//   BranchE, JalrE, JalD        control redirects
//   Rs*/Rd*, RegRead*, RegWrite*, MemToRegE   operand and writeback info per stage
//   McIssueE/McRdE, McDoneW/McRdW             multi-cycle op issue and writeback
//   Stall*/Flush*               stage-register controls
//   Forward1E/2E                00 regfile, 10 from M, 01 from W
//   StallCnt                    saturating count of cycles with StallF=1
module hazard_ctrl_mc #(
  parameter int AW       = 5,
  parameter int MC_DEPTH = 2,
  parameter int CNT_W    = 16
) (
  input  logic             CPU_CLK,
  input  logic             CPU_RSTN,
  input  logic             ICacheMiss,
  input  logic             DCacheMiss,
  input  logic             BranchE,
  input  logic             JalrE,
  input  logic             JalD,
  input  logic [AW-1:0]    Rs1D,
  input  logic [AW-1:0]    Rs2D,
  input  logic [AW-1:0]    Rs1E,
  input  logic [AW-1:0]    Rs2E,
  input  logic [AW-1:0]    RdE,
  input  logic [AW-1:0]    RdM,
  input  logic [AW-1:0]    RdW,
  input  logic [1:0]       RegReadD,
  input  logic [1:0]       RegReadE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemToRegE,
  input  logic             McIssueE,
  input  logic [AW-1:0]    McRdE,
  input  logic             McDoneW,
  input  logic [AW-1:0]    McRdW,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             StallW,
  output logic             FlushF,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic [1:0]       Forward1E,
  output logic [1:0]       Forward2E,
  output logic [CNT_W-1:0] StallCnt
);
  localparam int NREG = 2 ** AW;
  localparam logic [1:0] S_RUN = 2'd0, S_DMISS = 2'd1, S_IMISS = 2'd2;
  localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};
  logic [NREG-1:0]  busy_q, busy_d;
  logic [2:0]       mc_cnt_q, mc_cnt_d;
  logic             redir_pend_q, redir_pend_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic strc, raw, lu, hz, rd_e, rd_d, imiss, issue_ok;
  // a full MC unit only blocks when no slot frees up in the same cycle
  assign strc  = (mc_cnt_q == 3'(MC_DEPTH)) && McIssueE && !McDoneW;
  assign raw   = (RegReadD[1] && Rs1D != '0 && busy_q[Rs1D]) ||
                 (RegReadD[0] && Rs2D != '0 && busy_q[Rs2D]);
  assign lu    = MemToRegE && RdE != '0 &&
                 ((RegReadD[1] && Rs1D == RdE) || (RegReadD[0] && Rs2D == RdE));
  // a redirect latched during a D miss replays as an EX redirect
  assign rd_e  = BranchE || JalrE || redir_pend_q;
  assign rd_d  = rd_e || JalD;
  assign hz    = (raw || lu) && !rd_d;
  assign imiss = ICacheMiss && !DCacheMiss;
  always_comb begin
    {StallF, StallD, StallE, StallM, StallW} = '0;
    {FlushD, FlushE, FlushM, FlushW} = '0;
    FlushF = !CPU_RSTN;
    if (!CPU_RSTN) begin
      {FlushD, FlushE, FlushM, FlushW} = '1;
    end else if (DCacheMiss) begin
      {StallF, StallD, StallE, StallM} = '1;
      FlushW = 1'b1;
    end else if (strc) begin
      {StallF, StallD, StallE} = '1;
      FlushM = 1'b1;
    end else begin
      StallF = imiss || hz;
      StallD = hz;
      FlushD = rd_d || (imiss && !hz);
      FlushE = rd_e || hz;
    end
  end
  assign Forward1E = (!CPU_RSTN || !RegReadE[1] || Rs1E == '0) ? 2'b00 :
                     (RegWriteM && Rs1E == RdM) ? 2'b10 :
                     (RegWriteW && Rs1E == RdW) ? 2'b01 : 2'b00;
  assign Forward2E = (!CPU_RSTN || !RegReadE[0] || Rs2E == '0) ? 2'b00 :
                     (RegWriteM && Rs2E == RdM) ? 2'b10 :
                     (RegWriteW && Rs2E == RdW) ? 2'b01 : 2'b00;
  assign StallCnt  = cnt_q;
  assign issue_ok  = McIssueE && !StallE;
  // set is applied after clear so an issue to the same reg wins
  assign busy_d    = (busy_q & ~(McDoneW ? ONE << McRdW : '0)) |
                     ((issue_ok && McRdE != '0) ? ONE << McRdE : '0);
  assign mc_cnt_d  = mc_cnt_q + 3'(issue_ok) - 3'(McDoneW && mc_cnt_q != '0);
  // a pending redirect blocked by a structural stall waits for the next free cycle
  assign redir_pend_d = DCacheMiss ? (redir_pend_q || BranchE || JalrE || JalD)
                                   : (redir_pend_q && strc);
  assign state_d   = DCacheMiss ? S_DMISS :
                     (ICacheMiss && state_q != S_DMISS) ? S_IMISS : S_RUN;
  assign cnt_d     = (StallF && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge CPU_CLK) begin
    if (!CPU_RSTN) begin
      busy_q       <= '0;
      mc_cnt_q     <= '0;
      redir_pend_q <= 1'b0;
      state_q      <= S_RUN;
      cnt_q        <= '0;
    end else begin
      busy_q       <= busy_d;
      mc_cnt_q     <= mc_cnt_d;
      redir_pend_q <= redir_pend_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// tb_hazard_ctrl_mc: scoreboard-driven scenario bench for hazard_ctrl_mc
module tb_hazard_ctrl_mc;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int SMAX = 2 ** CW - 1;
  typedef logic [13+CW:0] vec_t;
  logic CPU_CLK = 1'b0;
  logic CPU_RSTN = 1'b0;
  logic ICacheMiss, DCacheMiss, BranchE, JalrE, JalD;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, McRdE, McRdW;
  logic [1:0] RegReadD, RegReadE;
  logic RegWriteM, RegWriteW, MemToRegE, McIssueE, McDoneW;
  logic StallF, StallD, StallE, StallM, StallW;
  logic FlushF, FlushD, FlushE, FlushM, FlushW;
  logic [1:0] Forward1E, Forward2E;
  logic [CW-1:0] StallCnt;
  vec_t q[$];
  int total = 0;
  int bad = 0;
  int sc = 0;
  hazard_ctrl_mc #(.AW(AW), .MC_DEPTH(2), .CNT_W(CW)) dut (
    .CPU_CLK(CPU_CLK), .CPU_RSTN(CPU_RSTN),
    .ICacheMiss(ICacheMiss), .DCacheMiss(DCacheMiss),
    .BranchE(BranchE), .JalrE(JalrE), .JalD(JalD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegReadD(RegReadD), .RegReadE(RegReadE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemToRegE(MemToRegE),
    .McIssueE(McIssueE), .McRdE(McRdE), .McDoneW(McDoneW), .McRdW(McRdW),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushF(FlushF), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .Forward1E(Forward1E), .Forward2E(Forward2E), .StallCnt(StallCnt)
  );
  always #5 CPU_CLK = ~CPU_CLK;
  // expected = stalls F..W, flushes F..W, fwd1, fwd2, stall count before this cycle
  function automatic vec_t ex(input logic [4:0] s, input logic [4:0] f, input logic [3:0] fw);
    return {s, f, fw, CW'(sc)};
  endfunction
  function automatic vec_t got();
    return {StallF, StallD, StallE, StallM, StallW, FlushF, FlushD, FlushE, FlushM, FlushW,
            Forward1E, Forward2E, StallCnt};
  endfunction
  task automatic sc_upd(input vec_t x);
    if (!CPU_RSTN) sc = 0;
    else if (x[13+CW] && sc < SMAX) sc++;
  endtask
  task automatic idle();
    CPU_RSTN = 1'b1;
    {ICacheMiss, DCacheMiss, BranchE, JalrE, JalD} = '0;
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, McRdE, McRdW} = '0;
    {RegReadD, RegReadE} = '0;
    {RegWriteM, RegWriteW, MemToRegE, McIssueE, McDoneW} = '0;
  endtask
  task automatic next_cycle();
    @(posedge CPU_CLK);
    #1;
  endtask
  task automatic do_reset();
    idle();
    CPU_RSTN = 1'b0;
    next_cycle();
    idle();
    sc = 0;
  endtask
  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      vec_t g, x;
      idle();
      case (c)
        0: begin
          CPU_RSTN = 0; DCacheMiss = 1; McIssueE = 1; McRdE = 5; MemToRegE = 1; RdE = 5;
          Rs1D = 5; RegReadD = 2'b10; Rs1E = 3; RdM = 3; RegWriteM = 1; RegReadE = 2'b11;
          q.push_back(ex(5'b00000, 5'b11111, 4'b0000));
        end
        1: begin
          CPU_RSTN = 0; ICacheMiss = 1; BranchE = 1; JalD = 1; Rs2E = 4; RdW = 4; RegWriteW = 1;
          RegReadE = 2'b01;
          q.push_back(ex(5'b00000, 5'b11111, 4'b0000));
        end
        default: begin
          Rs1D = 5; RegReadD = 2'b10;
          q.push_back(ex(5'b00000, 5'b00000, 4'b0000));
        end
      endcase
      @(negedge CPU_CLK);
      g = got(); x = q.pop_front(); total++;
      if (g !== x) begin bad++; $display("FAIL reset c%0d got=%b exp=%b", c, g, x); end
      sc_upd(x);
      next_cycle();
    end
  endtask
  task automatic test_load_use();
    for (int c = 0; c < 6; c++) begin
      vec_t g, x;
      idle();
      case (c)
        0: begin MemToRegE = 1; RdE = 5; Rs1D = 5; RegReadD = 2'b10;
                 q.push_back(ex(5'b11000, 5'b00100, 4'b0000)); end
        1: begin Rs1E = 5; RegReadE = 2'b10; RdW = 5; RegWriteW = 1;
                 q.push_back(ex(5'b00000, 5'b00000, 4'b0100)); end
        2: begin MemToRegE = 1; RdE = 5; Rs2D = 5; RegReadD = 2'b01;
                 q.push_back(ex(5'b11000, 5'b00100, 4'b0000)); end
        3: begin MemToRegE = 1; RdE = 0; Rs1D = 0; RegReadD = 2'b10;
                 q.push_back(ex(5'b00000, 5'b00000, 4'b0000)); end
        4: begin MemToRegE = 1; RdE = 5; Rs1D = 5; RegReadD = 2'b00;
                 q.push_back(ex(5'b00000, 5'b00000, 4'b0000)); end
        default: begin MemToRegE = 1; RdE = 5; Rs1D = 5; RegReadD = 2'b10; JalD = 1;
                 q.push_back(ex(5'b00000, 5'b01000, 4'b0000)); end
      endcase
      @(negedge CPU_CLK);
      g = got(); x = q.pop_front(); total++;
      if (g !== x) begin bad++; $display("FAIL load_use c%0d got=%b exp=%b", c, g, x); end
      sc_upd(x);
      next_cycle();
    end
  endtask
  task automatic test_scoreboard();
    for (int c = 0; c < 7; c++) begin
      vec_t g, x;
      idle();
      Rs2D = 7; RegReadD = 2'b01;
      case (c)
        0: begin RegReadD = 2'b00; McIssueE = 1; McRdE = 7;
                 q.push_back(ex(5'b00000, 5'b00000, 4'b0000)); end
        2: begin RegReadD = 2'b10; q.push_back(ex(5'b00000, 5'b00000, 4'b0000)); end
        3: begin BranchE = 1; q.push_back(ex(5'b00000, 5'b01100, 4'b0000)); end
        5: begin McDoneW = 1; McRdW = 7; q.push_back(ex(5'b11000, 5'b00100, 4'b0000)); end
        6: q.push_back(ex(5'b00000, 5'b00000, 4'b0000));
        default: q.push_back(ex(5'b11000, 5'b00100, 4'b0000));
      endcase
      @(negedge CPU_CLK);
      g = got(); x = q.pop_front(); total++;
      if (g !== x) begin bad++; $display("FAIL scoreboard c%0d got=%b exp=%b", c, g, x); end
      sc_upd(x);
      next_cycle();
    end
  endtask
  task automatic test_structural();
    for (int c = 0; c < 11; c++) begin
      vec_t g, x;
      idle();
      case (c)
        0: begin McIssueE = 1; McRdE = 1; q.push_back(ex(5'b00000, 5'b00000, 4'b0000)); end
        1: begin McIssueE = 1; McRdE = 2; q.push_back(ex(5'b00000, 5'b00000, 4'b0000)); end
        2: begin McIssueE = 1; McRdE = 3; q.push_back(ex(5'b11100, 5'b00010, 4'b0000)); end
        3: begin McIssueE = 1; McRdE = 3; McDoneW = 1; McRdW = 1;
                 q.push_back(ex(5'b00000, 5'b00000, 4'b0000)); end
        4: begin Rs1D = 3; RegReadD = 2'b10; McDoneW = 1; McRdW = 2;
                 q.push_back(ex(5'b11000, 5'b00100, 4'b0000)); end
        5: begin Rs1D = 1; RegReadD = 2'b10; q.push_back(ex(5'b00000, 5'b00000, 4'b0000)); end
        6: begin McDoneW = 1; McRdW = 3; q.push_back(ex(5'b00000, 5'b00000, 4'b0000)); end
        7: begin McDoneW = 1; McRdW = 0; q.push_back(ex(5'b00000, 5'b00000, 4'b0000)); end
        8: begin McIssueE = 1; McRdE = 4; q.push_back(ex(5'b00000, 5'b00000, 4'b0000)); end
        9: begin McIssueE = 1; McRdE = 5; q.push_back(ex(5'b00000, 5'b00000, 4'b0000)); end
        default: begin McIssueE = 1; McRdE = 6; q.push_back(ex(5'b11100, 5'b00010, 4'b0000)); end
      endcase
      @(negedge CPU_CLK);
      g = got(); x = q.pop_front(); total++;
      if (g !== x) begin bad++; $display("FAIL structural c%0d got=%b exp=%b", c, g, x); end
      sc_upd(x);
      next_cycle();
    end
  endtask
  task automatic test_dmiss_branch();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      vec_t g, x;
      idle();
      case (c)
        0, 2, 3: begin DCacheMiss = 1; q.push_back(ex(5'b11110, 5'b00001, 4'b0000)); end
        1: begin DCacheMiss = 1; BranchE = 1; q.push_back(ex(5'b11110, 5'b00001, 4'b0000)); end
        4: q.push_back(ex(5'b00000, 5'b01100, 4'b0000));
        6: begin ICacheMiss = 1; q.push_back(ex(5'b10000, 5'b01000, 4'b0000)); end
        7: begin ICacheMiss = 1; BranchE = 1; q.push_back(ex(5'b10000, 5'b01100, 4'b0000)); end
        8: begin ICacheMiss = 1; DCacheMiss = 1; q.push_back(ex(5'b11110, 5'b00001, 4'b0000)); end
        10: begin DCacheMiss = 1; JalD = 1; q.push_back(ex(5'b11110, 5'b00001, 4'b0000)); end
        11: q.push_back(ex(5'b00000, 5'b01100, 4'b0000));
        default: q.push_back(ex(5'b00000, 5'b00000, 4'b0000));
      endcase
      @(negedge CPU_CLK);
      g = got(); x = q.pop_front(); total++;
      if (g !== x) begin bad++; $display("FAIL dmiss_branch c%0d got=%b exp=%b", c, g, x); end
      sc_upd(x);
      next_cycle();
    end
  endtask
  task automatic test_forward();
    for (int c = 0; c < 5; c++) begin
      vec_t g, x;
      idle();
      Rs1E = 3; Rs2E = 3; RdM = 3; RdW = 3; RegWriteM = 1; RegWriteW = 1; RegReadE = 2'b11;
      case (c)
        0: q.push_back(ex(5'b00000, 5'b00000, 4'b1010));
        1: begin Rs1E = 0; q.push_back(ex(5'b00000, 5'b00000, 4'b0010)); end
        2: begin RegWriteM = 0; q.push_back(ex(5'b00000, 5'b00000, 4'b0101)); end
        3: begin RegReadE = 2'b00; q.push_back(ex(5'b00000, 5'b00000, 4'b0000)); end
        default: begin Rs1E = 4; Rs2E = 6; RdM = 6; RdW = 4;
                 q.push_back(ex(5'b00000, 5'b00000, 4'b0110)); end
      endcase
      @(negedge CPU_CLK);
      g = got(); x = q.pop_front(); total++;
      if (g !== x) begin bad++; $display("FAIL forward c%0d got=%b exp=%b", c, g, x); end
      sc_upd(x);
      next_cycle();
    end
  endtask
  task automatic test_saturation();
    for (int c = 0; c < 21; c++) begin
      vec_t g, x;
      idle();
      ICacheMiss = (c < 20);
      if (c < 20) q.push_back(ex(5'b10000, 5'b01000, 4'b0000));
      else q.push_back(ex(5'b00000, 5'b00000, 4'b0000));
      @(negedge CPU_CLK);
      g = got(); x = q.pop_front(); total++;
      if (g !== x) begin bad++; $display("FAIL saturation c%0d got=%b exp=%b", c, g, x); end
      sc_upd(x);
      next_cycle();
    end
  endtask
  task automatic test_reset_mid_op();
    for (int c = 0; c < 9; c++) begin
      vec_t g, x;
      idle();
      case (c)
        0: begin McIssueE = 1; McRdE = 9; q.push_back(ex(5'b00000, 5'b00000, 4'b0000)); end
        1: begin CPU_RSTN = 0; DCacheMiss = 1; BranchE = 1; Rs1D = 9; RegReadD = 2'b10;
                 McIssueE = 1; McRdE = 9; q.push_back(ex(5'b00000, 5'b11111, 4'b0000)); end
        2: begin Rs1D = 9; RegReadD = 2'b10; q.push_back(ex(5'b00000, 5'b00000, 4'b0000)); end
        3: begin McIssueE = 1; McRdE = 1; q.push_back(ex(5'b00000, 5'b00000, 4'b0000)); end
        4: begin McIssueE = 1; McRdE = 2; q.push_back(ex(5'b00000, 5'b00000, 4'b0000)); end
        5: begin McIssueE = 1; McRdE = 3; q.push_back(ex(5'b11100, 5'b00010, 4'b0000)); end
        6: begin DCacheMiss = 1; BranchE = 1; q.push_back(ex(5'b11110, 5'b00001, 4'b0000)); end
        7: begin CPU_RSTN = 0; q.push_back(ex(5'b00000, 5'b11111, 4'b0000)); end
        default: q.push_back(ex(5'b00000, 5'b00000, 4'b0000));
      endcase
      @(negedge CPU_CLK);
      g = got(); x = q.pop_front(); total++;
      if (g !== x) begin bad++; $display("FAIL reset_mid_op c%0d got=%b exp=%b", c, g, x); end
      sc_upd(x);
      next_cycle();
    end
  endtask
  initial begin
    idle();
    CPU_RSTN = 1'b0;
    next_cycle();
    test_reset();
    test_load_use();
    test_scoreboard();
    test_structural();
    test_dmiss_branch();
    test_forward();
    test_saturation();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
